// File: rtl/serial_addsub8.sv
// serial_addsub8: bit-serial unsigned adder/subtractor.
//
// One result bit is produced per clock by a single full-adder cell and a
// carry/borrow flip-flop. An operation takes WIDTH cycles from the accepting
// edge to the cycle in which `done` is high. Back-to-back throughput is one
// operation every WIDTH+2 cycles.
//
// State table:
//   state  | meaning
//   S_IDLE | waiting for start; operands are captured on the accepting edge
//   S_RUN  | one bit per cycle through the shared full-adder cell
//   S_DONE | new sum/c_out visible, done pulse high for this one cycle
//
// Ports:
//   clk    in   single clock, rising edge
//   rst    in   asynchronous active-high reset
//   start  in   request, sampled only in S_IDLE
//   A, B   in   WIDTH-bit unsigned operands, captured on acceptance
//   mode   in   1 = A+B, 0 = A-B, captured on acceptance
//   sum    out  last completed result (mod 2^WIDTH)
//   c_out  out  carry out (add) or borrow, A < B (subtract)
//   busy   out  high in S_RUN
//   done   out  one-cycle pulse when a new result first appears
module serial_addsub8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mode,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_shift_a;
    logic [WIDTH-1:0] r_shift_b;
    logic [WIDTH-1:0] r_shift_r;
    logic [WIDTH-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cy;
    logic             r_mode;
    logic             r_c_out;

    logic             w_a0;
    logic             w_b0;
    logic             w_s;
    logic             w_cy_next;
    logic             w_last;
    logic [WIDTH-1:0] w_shift_r_next;

    assign w_a0           = r_shift_a[0];
    assign w_b0           = r_shift_b[0];
    assign w_s            = w_a0 ^ w_b0 ^ r_cy;
    assign w_cy_next      = (w_a0 & w_b0) | (w_a0 & r_cy) | (w_b0 & r_cy);
    assign w_shift_r_next = {w_s, r_shift_r[WIDTH-1:1]};
    assign w_last         = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift_a <= '0;
            r_shift_b <= '0;
            r_shift_r <= '0;
            r_sum     <= '0;
            r_cnt     <= '0;
            r_cy      <= 1'b0;
            r_mode    <= 1'b0;
            r_c_out   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // Subtract is A + ~B + 1: invert B and preset carry-in.
                        r_shift_a <= A;
                        r_shift_b <= mode ? B : ~B;
                        r_cy      <= ~mode;
                        r_mode    <= mode;
                        r_cnt     <= '0;
                    end
                end
                S_RUN: begin
                    r_shift_a <= r_shift_a >> 1;
                    r_shift_b <= r_shift_b >> 1;
                    r_shift_r <= w_shift_r_next;
                    r_cy      <= w_cy_next;
                    r_cnt     <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_sum   <= w_shift_r_next;
                        // A final carry of 0 in subtract mode means a borrow.
                        r_c_out <= r_mode ? w_cy_next : ~w_cy_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum   = r_sum;
    assign c_out = r_c_out;
    assign busy  = (r_state == S_RUN);
    assign done  = (r_state == S_DONE);

endmodule

// File: doc/serial_addsub8.md
# serial_addsub8

Bit-serial 8-bit unsigned adder/subtractor that computes one result bit per clock with a single shared full-adder cell and a carry/borrow flip-flop. It is the sequential, area-minimal counterpart to the combinational ripple-carry `adder`. It keeps the same operand/result naming (`A`, `B`, `mode`, `sum`, `c_out`) and adds the inverse operation, subtraction, with a start/done handshake. It is meant to replace `adder` in datapaths where latency is cheap and gates are not.

## Interface
- `WIDTH`, 8: operand and result width in bits. The bit counter is sized ceil(log2(WIDTH))+1.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous, active-high; clears all state immediately.
- `start`  input  1  request; sampled only in IDLE.
- `A`  input  WIDTH  operand A, unsigned; sampled on the accepting edge.
- `B`  input  WIDTH  operand B, unsigned; sampled on the accepting edge.
- `mode`  input  1  1 = add (A+B), 0 = subtract (A−B); sampled on the accepting edge.
- `sum`  output  WIDTH  registered result; holds the last completed result.
- `c_out`  output  1  add: carry out of the MSB. Subtract: borrow, 1 when A < B.
- `busy`  output  1  high in RUN.
- `done`  output  1  one-cycle pulse; high for the cycle in which a new `sum`/`c_out` first appear.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE → RUN when `start`=1 at an edge.
  - Load shift_a←A.
  - Load shift_b←(mode ? B : ~B).
  - Set cy←~mode, so carry-in is 1 for subtract (two's complement).
  - Set cnt←0.
- RUN, each edge:
  - Compute s = a0^b0^cy and cy ← majority(a0,b0,cy), where a0/b0 are the LSBs of shift_a/shift_b.
  - Shift s into the MSB of shift_r, shifting shift_r right.
  - Shift shift_a and shift_b right by one.
  - cnt←cnt+1.
- RUN → DONE on the edge where cnt==WIDTH−1 (the last bit is processed). On that same edge:
  - `sum`←final shift_r contents, including the last bit.
  - `c_out`←(mode ? cy_next : ~cy_next).
  - `done`←1.
- DONE → IDLE unconditionally on the next edge; `done`←0.
- `start` in RUN or DONE is ignored and not queued. A, B, and `mode` may change freely after acceptance without affecting the operation in flight.
- `sum`/`c_out` do not change during RUN; they update only on the RUN→DONE edge.
- Arithmetic: the result is modulo 2^WIDTH; there is no overflow flag.
  - Add: {c_out,sum} = A+B.
  - Subtract: sum = (A−B) mod 2^WIDTH, c_out = (A<B).
- Reset asserted at any time, including mid-RUN: state=IDLE, cnt=0, shift registers=0, cy=0, `sum`=0, `c_out`=0, `busy`=0, `done`=0. A partial result is discarded. After reset deassertion, the first `start` is accepted normally.

## Timing
- Reset values: `sum`=0, `c_out`=0, `busy`=0, `done`=0.
- Accepting edge is E0. `busy`=1 from after E0 until after E(WIDTH). `done`=1 and the result are valid after E(WIDTH). `done` drops after E(WIDTH+1).
- Latency from the accepting edge to `done`: WIDTH cycles (8).
- Earliest next acceptance is at E(WIDTH+2), because `start` is sampled in IDLE only. Back-to-back throughput is one operation per WIDTH+2 cycles.
- `start` held high continuously: a new operation is accepted at every IDLE, i.e. every WIDTH+2 cycles.
- `busy` and `done` are never high in the same cycle.

## Test plan
- Reset: assert `rst` asynchronously between edges → all outputs 0 immediately, without waiting for a clock edge. Release and run 3 idle cycles → outputs stay 0 and `busy`=0.
- Add set, mode=1, one op per handshake:
  - 110+2 → sum=112, c_out=0.
  - 127+126 → sum=253, c_out=0.
  - 19+12 → sum=31, c_out=0.
  - 200+100 → sum=44, c_out=1.
  - For each: `done` exactly 8 cycles after acceptance, for one cycle only.
- Subtract set, mode=0:
  - 19−12 → sum=7, c_out=0.
  - 12−19 → sum=249, c_out=1.
  - 0−0 → sum=0, c_out=0.
  - 0−255 → sum=1, c_out=1.
- Handshake: pulse `start` again in RUN cycles 1..7 and during DONE with different operands → ignored; the original result is reported. Change A/B/mode mid-RUN → no effect on the result. Hold `start` high continuously → acceptances spaced exactly 10 cycles apart.
- Reset mid-operation: accept 255+255, assert `rst` at RUN cycle 4 → no `done`, outputs 0. Then 1+1 → sum=2, c_out=0 after 8 cycles.
- Random: 1000 random A/B/mode operations compared against the reference model (A+B or A−B, plus the carry/borrow rule), with `sum` checked stable throughout RUN.
